// File: rtl/synapse_accumulator.sv
// Synapse accumulator: latches one spike vector, walks it one bit per cycle and
// sums the weights of active inputs with saturation at 255.
module synapse_accumulator #(
  parameter int unsigned N_INPUTS = 8,
  parameter int unsigned IDX_W    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_we,
  input  logic [IDX_W-1:0]    w_addr,
  input  logic [7:0]          w_data,
  input  logic [N_INPUTS-1:0] spike_in,
  input  logic                spike_valid,
  output logic                spike_ready,
  output logic [7:0]          weight_sum,
  output logic                sum_valid,
  input  logic                sum_ready,
  output logic                sat
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_INPUTS - 1);

  state_e              state_q, state_d;
  logic [7:0]          weights_q [N_INPUTS];
  logic [N_INPUTS-1:0] spikes_q, spikes_d;
  logic [7:0]          acc_q, acc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                sat_q, sat_d;
  logic [8:0]          sum;

  // Registered read: a write landing on the same edge is not seen this cycle.
  assign sum = {1'b0, acc_q} + {1'b0, weights_q[idx_q]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_INPUTS; i++) begin
        weights_q[i] <= '0;
      end
    end else if (w_we && (32'(w_addr) < N_INPUTS)) begin
      weights_q[w_addr] <= w_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    spikes_d = spikes_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    sat_d    = sat_q;
    case (state_q)
      StIdle: begin
        if (spike_valid) begin
          spikes_d = spike_in;
          acc_d    = '0;
          sat_d    = 1'b0;
          idx_d    = '0;
          state_d  = StAccum;
        end
      end
      StAccum: begin
        if (spikes_q[idx_q]) begin
          if (sum[8]) begin
            acc_d = 8'hFF;
            sat_d = 1'b1;
          end else begin
            acc_d = sum[7:0];
          end
        end
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (sum_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      spikes_q <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      spikes_q <= spikes_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      sat_q    <= sat_d;
    end
  end

  assign spike_ready = (state_q == StIdle);
  assign sum_valid   = (state_q == StDone);
  assign weight_sum  = acc_q;
  assign sat         = sat_q;

endmodule

// File: tb/tb_synapse_accumulator.sv
// Bench for synapse_accumulator: reference model of the saturating weighted sum
// plus a per-cycle compare process, and a small out-of-range-write instance.
module tb_synapse_accumulator;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       w_we;
  logic [2:0] w_addr;
  logic [7:0] w_data;
  logic [7:0] spike_in;
  logic       spike_valid;
  logic       spike_ready;
  logic [7:0] weight_sum;
  logic       sum_valid;
  logic       sum_ready;
  logic       sat;

  logic       s_we;
  logic [2:0] s_addr;
  logic [7:0] s_data;
  logic [5:0] s_spike;
  logic       s_sv;
  logic       s_sr;
  logic [7:0] s_sum;
  logic       s_valid;
  logic       s_rdy;
  logic       s_sat;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mw [N];
  int q_sum [$];
  int q_sat [$];
  bit exp_ready;
  int exp_valid_at;

  synapse_accumulator #(.N_INPUTS(8), .IDX_W(3)) dut (
    .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .spike_in(spike_in), .spike_valid(spike_valid), .spike_ready(spike_ready),
    .weight_sum(weight_sum), .sum_valid(sum_valid), .sum_ready(sum_ready), .sat(sat)
  );

  synapse_accumulator #(.N_INPUTS(6), .IDX_W(3)) dut_small (
    .clk(clk), .rst(rst), .w_we(s_we), .w_addr(s_addr), .w_data(s_data),
    .spike_in(s_spike), .spike_valid(s_sv), .spike_ready(s_sr),
    .weight_sum(s_sum), .sum_valid(s_valid), .sum_ready(s_rdy), .sat(s_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_spike_ready", spike_ready, 1);
    chk("rst_sum_valid", sum_valid, 0);
    chk("rst_weight_sum", weight_sum, 0);
    chk("rst_sat", sat, 0);
  endtask

  task automatic clear_model();
    foreach (mw[i]) mw[i] = 0;
    q_sum.delete();
    q_sat.delete();
    exp_ready    = 1'b1;
    exp_valid_at = -1;
    sum_ready    = 1'b0;
    spike_valid  = 1'b0;
    w_we         = 1'b0;
  endtask

  // Called at a falling edge; asserts reset asynchronously mid-cycle.
  task automatic mid_reset();
    #2 rst = 1'b1;
    #1 chk_reset_outputs();
    clear_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_w(input int addr, input int data);
    @(negedge clk);
    w_we = 1'b1; w_addr = 3'(addr); w_data = 8'(data);
    mw[addr] = data;
    @(negedge clk);
    w_we = 1'b0;
  endtask

  task automatic send(input logic [7:0] vec, input int hold, input bit rnd_w,
                      input int haz_idx, input int haz_data,
                      input int lit_sum, input int lit_sat);
    int acc;
    int sf;
    int n;
    n = 0;
    @(negedge clk);
    while (!spike_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!spike_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: spike_ready still %0d after %0d cycles", spike_ready, n);
      return;
    end
    spike_valid = 1'b1;
    spike_in    = vec;
    @(negedge clk);
    spike_valid  = 1'b0;
    spike_in     = 8'($urandom);
    exp_ready    = 1'b0;
    exp_valid_at = cyc + N;
    acc = 0;
    sf  = 0;
    for (int i = 0; i < N; i++) begin
      // Input i is summed with the weight held before this cycle's write lands.
      if (vec[i]) begin
        acc = acc + mw[i];
        if (acc > 255) begin
          acc = 255;
          sf  = 1;
        end
      end
      w_we = 1'b0;
      if (i == haz_idx) begin
        w_we = 1'b1; w_addr = 3'(i); w_data = 8'(haz_data);
      end else if (rnd_w && $urandom_range(0, 2) == 0) begin
        w_we = 1'b1; w_addr = 3'($urandom); w_data = 8'($urandom);
      end
      if (w_we) mw[w_addr] = int'(w_data);
      if (i == N - 1) begin
        q_sum.push_back(acc);
        q_sat.push_back(sf);
        if (hold == 0) sum_ready = 1'b1;
      end
      @(negedge clk);
    end
    w_we = 1'b0;
    if (lit_sum >= 0) begin
      chk("lit_weight_sum", weight_sum, lit_sum);
      chk("lit_sat", sat, lit_sat);
    end
    if (hold > 0) begin
      spike_valid = 1'b1;
      spike_in    = 8'hFF;
      repeat (hold) @(negedge clk);
      sum_ready   = 1'b1;
      spike_valid = 1'b0;
    end
    @(negedge clk);
    sum_ready = 1'b0;
    exp_ready = 1'b1;
  endtask

  // Per-cycle comparison of handshake and result against the model.
  initial begin
    bit prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        chk("spike_ready", spike_ready, int'(exp_ready));
        if (sum_valid && !prev_valid) chk("valid_rise_cycle", cyc, exp_valid_at);
        else if (!sum_valid && exp_valid_at == cyc) chk("valid_on_time", sum_valid, 1);
        if (sum_valid) begin
          chk("pending_results", q_sum.size(), 1);
          if (q_sum.size() > 0) begin
            chk("weight_sum", weight_sum, q_sum[0]);
            chk("sat", sat, q_sat[0]);
            if (sum_ready) begin
              void'(q_sum.pop_front());
              void'(q_sat.pop_front());
              exp_valid_at = -1;
            end
          end
        end
      end
      prev_valid = sum_valid;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time %0t exceeded", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    w_addr = '0; w_data = '0; spike_in = '0;
    s_we = 1'b0; s_addr = '0; s_data = '0; s_spike = '0; s_sv = 1'b0; s_rdy = 1'b0;
    clear_model();
    #1 chk_reset_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // No prior writes: everything sums to zero.
    send(8'hFF, 0, 1'b0, -1, 0, 0, 0);

    for (int i = 0; i < N; i++) write_w(i, 10 * (i + 1));
    send(8'b1000_0101, 0, 1'b0, -1, 0, 120, 0);

    // Result 120 still shown; async reset must clear it immediately.
    @(negedge clk);
    mid_reset();

    for (int i = 0; i < N; i++) write_w(i, 100);
    send(8'h07, 0, 1'b0, -1, 0, 255, 1);
    send(8'h01, 0, 1'b0, -1, 0, 100, 0);
    send(8'h03, 5, 1'b0, -1, 0, 200, 0);

    write_w(3, 5);
    send(8'h08, 0, 1'b0, 3, 200, 5, 0);
    send(8'h08, 0, 1'b0, -1, 0, 200, 0);

    // Reset during the third accumulate cycle.
    @(negedge clk);
    spike_valid = 1'b1;
    spike_in    = 8'hFF;
    @(negedge clk);
    spike_valid = 1'b0;
    exp_ready   = 1'b0;
    repeat (2) @(negedge clk);
    mid_reset();
    repeat (12) @(negedge clk);
    send(8'hFF, 0, 1'b0, -1, 0, 0, 0);
    write_w(0, 7);
    send(8'h01, 0, 1'b0, -1, 0, 7, 0);

    for (int i = 0; i < N; i++) write_w(i, $urandom_range(0, 255));
    for (int k = 0; k < 40; k++) begin
      send(8'($urandom), $urandom_range(0, 3), 1'b1, -1, 0, -1, 0);
    end

    // Small instance: writes to addresses 6 and 7 must be dropped.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s_we = 1'b1; s_addr = 3'(i); s_data = (i < 6) ? 8'(i + 1) : 8'd99;
    end
    @(negedge clk);
    s_we = 1'b0;
    s_sv = 1'b1; s_spike = 6'h3F;
    @(negedge clk);
    s_sv = 1'b0;
    n = 0;
    while (!s_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("small_latency", n, 6);
    chk("small_valid", s_valid, 1);
    chk("small_sum", s_sum, 21);
    chk("small_sat", s_sat, 0);
    s_rdy = 1'b1;
    @(negedge clk);
    s_rdy = 1'b0;
    chk("small_ready_back", s_sr, 1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
